// File: rtl/matching_memory_pkg.sv
// Shared widths, opcodes, payload structs and helpers for the matching memory.
package matching_memory_pkg;

  localparam int unsigned DATA_WIDTH           = 32;
  localparam int unsigned ADDR_WIDTH           = 16;
  localparam int unsigned COLOR_WIDTH          = 8;
  localparam int unsigned INDEX_WIDTH          = 6;
  localparam int unsigned ENTRIES              = 1 << INDEX_WIDTH;
  localparam int unsigned OPT_WIDTH            = 3;
  localparam int unsigned WORKER_RESULT_WIDTH  = OPT_WIDTH + ADDR_WIDTH + COLOR_WIDTH + DATA_WIDTH;
  localparam int unsigned PACKET_REQUEST_WIDTH = OPT_WIDTH + ADDR_WIDTH + COLOR_WIDTH + 2 * DATA_WIDTH;
  localparam int unsigned STAT_WIDTH           = 16;

  localparam logic [OPT_WIDTH-1:0] DEST_OPTION_EXEC  = 3'd0;
  localparam logic [OPT_WIDTH-1:0] DEST_OPTION_ONE   = 3'd1;
  localparam logic [OPT_WIDTH-1:0] DEST_OPTION_LEFT  = 3'd2;
  localparam logic [OPT_WIDTH-1:0] DEST_OPTION_RIGHT = 3'd3;
  localparam logic [OPT_WIDTH-1:0] DEST_OPTION_END   = 3'd4;

  typedef enum logic [1:0] {
    S_RECEIVE = 2'd0,
    S_LOOKUP  = 2'd1,
    S_SEND    = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPT_WIDTH-1:0]   dest_option;
    logic [ADDR_WIDTH-1:0]  dest_addr;
    logic [COLOR_WIDTH-1:0] color;
    logic [DATA_WIDTH-1:0]  data;
  } worker_result_t;

  typedef struct packed {
    logic [OPT_WIDTH-1:0]   dest_option;
    logic [ADDR_WIDTH-1:0]  dest_addr;
    logic [COLOR_WIDTH-1:0] color;
    logic [DATA_WIDTH-1:0]  data1;
    logic [DATA_WIDTH-1:0]  data2;
  } packet_request_t;

  // side: 0 = LEFT operand, 1 = RIGHT operand
  typedef struct packed {
    logic                   side;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [COLOR_WIDTH-1:0] color;
    logic [DATA_WIDTH-1:0]  data;
  } entry_t;

  function automatic logic [INDEX_WIDTH-1:0] calc_index(input logic [ADDR_WIDTH-1:0]  addr,
                                                         input logic [COLOR_WIDTH-1:0] color);
    return addr[INDEX_WIDTH-1:0] ^ INDEX_WIDTH'(color);
  endfunction

  function automatic packet_request_t make_packet_request(input logic [ADDR_WIDTH-1:0]  addr,
                                                          input logic [COLOR_WIDTH-1:0] color,
                                                          input logic [DATA_WIDTH-1:0]  left,
                                                          input logic [DATA_WIDTH-1:0]  right);
    packet_request_t pr;
    pr.dest_option = DEST_OPTION_EXEC;
    pr.dest_addr   = addr;
    pr.color       = color;
    pr.data1       = left;
    pr.data2       = right;
    return pr;
  endfunction

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v, input logic en);
    return (en && (v != '1)) ? v + STAT_WIDTH'(1) : v;
  endfunction

endpackage

// File: rtl/matching_memory_if.sv
// Token input and packet-request output handshakes of the matching memory.
interface matching_memory_if;

  logic                                                 RECEIVE_WR_VALID;
  logic [matching_memory_pkg::WORKER_RESULT_WIDTH-1:0]  RECEIVE_WR_DATA;
  logic                                                 RECEIVE_WR_READY;
  logic                                                 SEND_PR_VALID;
  logic [matching_memory_pkg::PACKET_REQUEST_WIDTH-1:0] SEND_PR_DATA;
  logic                                                 SEND_PR_READY;

  modport slave (
    input  RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_PR_READY,
    output RECEIVE_WR_READY, SEND_PR_VALID, SEND_PR_DATA
  );

  modport master (
    output RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_PR_READY,
    input  RECEIVE_WR_READY, SEND_PR_VALID, SEND_PR_DATA
  );

endinterface

// File: rtl/matching_memory_token_store.sv
// Direct-mapped operand store: synchronous write, async read, separately
// resettable valid bits with a clear-all input.
module matching_memory_token_store
  import matching_memory_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   clear_all_i,
  input  logic [INDEX_WIDTH-1:0] idx_i,
  input  logic                   wr_en_i,
  input  entry_t                 wr_entry_i,
  input  logic                   clr_en_i,
  output logic                   rd_valid_c_o,
  output entry_t                 rd_entry_c_o
);

  logic [ENTRIES-1:0] valid_q;
  entry_t             mem_q [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (clear_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[idx_i] <= 1'b1;
    end else if (clr_en_i) begin
      valid_q[idx_i] <= 1'b0;
    end
  end

  // Payload is never reset; the valid bit alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[idx_i] <= wr_entry_i;
    end
  end

  assign rd_valid_c_o = valid_q[idx_i];
  assign rd_entry_c_o = mem_q[idx_i];

endmodule

// File: rtl/matching_memory.sv
// Pairs LEFT/RIGHT operand tokens by (dest_addr, color) and emits EXEC packet
// requests. Optional counters enabled by MATCHING_MEMORY_STATS_EN.
module matching_memory
  import matching_memory_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  matching_memory_if.slave      bus,
`ifdef MATCHING_MEMORY_STATS_EN
  output logic [STAT_WIDTH-1:0] STAT_STORED,
  output logic [STAT_WIDTH-1:0] STAT_MATCHED,
  output logic [STAT_WIDTH-1:0] STAT_DROPPED,
`endif
  output logic                  OVERFLOW
);

  state_e          state_q, state_d;
  worker_result_t  tok_q, tok_d;
  logic            rdy_q, rdy_d;
  logic            pr_valid_q, pr_valid_d;
  packet_request_t pr_data_q, pr_data_d;
  logic            ovf_q, ovf_d;

  logic                   st_wr_en, st_clr_en, st_rd_valid;
  logic                   drop_c;
  entry_t                 st_rd_entry, st_wr_entry;
  logic [INDEX_WIDTH-1:0] idx;
  logic                   tok_side, tok_known, tag_hit;

  assign idx       = calc_index(tok_q.dest_addr, tok_q.color);
  assign tok_side  = (tok_q.dest_option == DEST_OPTION_RIGHT);
  assign tok_known = (tok_q.dest_option == DEST_OPTION_LEFT) ||
                     (tok_q.dest_option == DEST_OPTION_RIGHT);
  assign tag_hit   = (st_rd_entry.addr == tok_q.dest_addr) &&
                     (st_rd_entry.color == tok_q.color);

  always_comb begin
    st_wr_entry.side  = tok_side;
    st_wr_entry.addr  = tok_q.dest_addr;
    st_wr_entry.color = tok_q.color;
    st_wr_entry.data  = tok_q.data;
  end

  matching_memory_token_store u_store (
    .clk_i        (CLK),
    .clear_all_i  (RST),
    .idx_i        (idx),
    .wr_en_i      (st_wr_en),
    .wr_entry_i   (st_wr_entry),
    .clr_en_i     (st_clr_en),
    .rd_valid_c_o (st_rd_valid),
    .rd_entry_c_o (st_rd_entry)
  );

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    tok_d      = tok_q;
    rdy_d      = 1'b0;
    pr_valid_d = pr_valid_q;
    pr_data_d  = pr_data_q;
    ovf_d      = ovf_q;
    st_wr_en   = 1'b0;
    st_clr_en  = 1'b0;
    drop_c     = 1'b0;

    case (state_q)
      S_RECEIVE: begin
        if (bus.RECEIVE_WR_VALID && rdy_q) begin
          tok_d   = bus.RECEIVE_WR_DATA;
          state_d = S_LOOKUP;
        end else begin
          rdy_d = 1'b1;
        end
      end
      S_LOOKUP: begin
        state_d = S_RECEIVE;
        if (!tok_known) begin
          // Non-operand tokens are silently consumed.
          state_d = S_RECEIVE;
        end else if (!st_rd_valid) begin
          st_wr_en = 1'b1;
        end else if (tag_hit && (st_rd_entry.side != tok_side)) begin
          st_clr_en  = 1'b1;
          pr_valid_d = 1'b1;
          state_d    = S_SEND;
          // Operand order follows the side, not the arrival order.
          pr_data_d  = tok_side
                     ? make_packet_request(tok_q.dest_addr, tok_q.color, st_rd_entry.data, tok_q.data)
                     : make_packet_request(tok_q.dest_addr, tok_q.color, tok_q.data, st_rd_entry.data);
        end else begin
          drop_c = 1'b1;
          ovf_d  = 1'b1;
        end
      end
      S_SEND: begin
        if (bus.SEND_PR_READY) begin
          pr_valid_d = 1'b0;
          state_d    = S_RECEIVE;
        end
      end
      default: state_d = S_RECEIVE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_RECEIVE;
      tok_q      <= '0;
      rdy_q      <= 1'b0;
      pr_valid_q <= 1'b0;
      pr_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tok_q      <= tok_d;
      rdy_q      <= rdy_d;
      pr_valid_q <= pr_valid_d;
      pr_data_q  <= pr_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.RECEIVE_WR_READY = rdy_q;
  assign bus.SEND_PR_VALID    = pr_valid_q;
  assign bus.SEND_PR_DATA     = pr_data_q;
  assign OVERFLOW             = ovf_q;

`ifdef MATCHING_MEMORY_STATS_EN
  logic [STAT_WIDTH-1:0] stored_q, matched_q, dropped_q;

  // Saturating outcome counters, stepped in the lookup cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      stored_q  <= '0;
      matched_q <= '0;
      dropped_q <= '0;
    end else begin
      stored_q  <= sat_inc(stored_q, st_wr_en);
      matched_q <= sat_inc(matched_q, st_clr_en);
      dropped_q <= sat_inc(dropped_q, drop_c);
    end
  end

  assign STAT_STORED  = stored_q;
  assign STAT_MATCHED = matched_q;
  assign STAT_DROPPED = dropped_q;
`endif

endmodule
